// File: rtl/ws2812_pkg.sv
// Shared definitions for the WS2812 chain driver and the pattern stage:
// FSM states, 100 MHz timing defaults and GRB colour constants.
package ws2812_pkg;

    localparam int BITS_PER_LED = 24;

    localparam int DEFAULT_NUM_LEDS = 5;
    localparam int DEFAULT_T0H      = 40;
    localparam int DEFAULT_T1H      = 80;
    localparam int DEFAULT_TBIT     = 125;
    localparam int DEFAULT_TRESET   = 5000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEND  = 2'd1,
        LATCH = 2'd2
    } state_t;

    // Colours are packed G[23:16], R[15:8], B[7:0] as the LEDs expect.
    localparam logic [BITS_PER_LED-1:0] OFF    = 24'h000000;
    localparam logic [BITS_PER_LED-1:0] RED    = 24'h00FF00;
    localparam logic [BITS_PER_LED-1:0] ORANGE = 24'h80FF00;
    localparam logic [BITS_PER_LED-1:0] GREEN  = 24'hFF0000;
    localparam logic [BITS_PER_LED-1:0] CYAN   = 24'hFF00FF;
    localparam logic [BITS_PER_LED-1:0] BLUE   = 24'h0000FF;
    localparam logic [BITS_PER_LED-1:0] VIOLET = 24'h0080FF;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Counter width for values 0..count-1, never narrower than one bit.
    function automatic int width_for(input int count);
        return (count > 1) ? $clog2(count) : 1;
    endfunction

endpackage

// File: rtl/ws2812_bit_timer.sv
// Pulse-width decision for one NZR bit: high phase length depends on the bit
// value, and end_of_bit marks the final tick of the bit period.
module ws2812_bit_timer
    import ws2812_pkg::*;
#(
    parameter int T0H    = DEFAULT_T0H,
    parameter int T1H    = DEFAULT_T1H,
    parameter int TBIT   = DEFAULT_TBIT,
    parameter int TICK_W = width_for(DEFAULT_TBIT)
) (
    input  logic [TICK_W-1:0] tick,
    input  logic              bit_value,
    output logic              high,
    output logic              end_of_bit
);

    logic [TICK_W-1:0] high_len;

    assign high_len   = bit_value ? TICK_W'(T1H) : TICK_W'(T0H);
    assign high       = (tick < high_len);
    assign end_of_bit = (tick == TICK_W'(TBIT - 1));

endmodule

// File: rtl/ws2812_tx.sv
// WS2812 serial line driver: captures a GRB frame on start, shifts it out MSB
// first as NZR pulses, then holds the line low for the latch interval.
module ws2812_tx
    import ws2812_pkg::*;
#(
    parameter int NUM_LEDS = DEFAULT_NUM_LEDS,
    parameter int T0H      = DEFAULT_T0H,
    parameter int T1H      = DEFAULT_T1H,
    parameter int TBIT     = DEFAULT_TBIT,
    parameter int TRESET   = DEFAULT_TRESET
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_LEDS*BITS_PER_LED-1:0] frame,
    input  logic                           start,
    output logic                           busy,
    output logic                           done,
    output logic                           dout
);

    localparam int FRAME_W = NUM_LEDS * BITS_PER_LED;
    localparam int TICK_W  = width_for(max_int(TBIT, TRESET));
    localparam int BIT_W   = width_for(FRAME_W);

    if (!(T0H > 0 && T0H < T1H && T1H < TBIT && TRESET >= 1)) begin : g_bad_timing
        $fatal(1, "ws2812_tx: timing parameters must satisfy 0 < T0H < T1H < TBIT and TRESET >= 1");
    end

    state_t               state_reg, state_next;
    logic [TICK_W-1:0]    tick_reg, tick_next;
    logic [BIT_W-1:0]     bit_cnt_reg, bit_cnt_next;
    logic [FRAME_W-1:0]   shreg_reg, shreg_next;
    logic                 done_reg, done_next;
    logic                 dout_reg;
    logic                 eob_reg;
    logic                 high_next;
    logic                 eob_next;

    // The timer looks one cycle ahead so dout and the end-of-bit flag come
    // straight from flops and line up with the tick they describe.
    ws2812_bit_timer #(
        .T0H    (T0H),
        .T1H    (T1H),
        .TBIT   (TBIT),
        .TICK_W (TICK_W)
    ) u_bit_timer (
        .tick       (tick_next),
        .bit_value  (shreg_next[FRAME_W-1]),
        .high       (high_next),
        .end_of_bit (eob_next)
    );

    always_comb begin
        state_next   = state_reg;
        tick_next    = tick_reg;
        bit_cnt_next = bit_cnt_reg;
        shreg_next   = shreg_reg;
        done_next    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next   = SEND;
                    tick_next    = '0;
                    bit_cnt_next = '0;
                    shreg_next   = frame;
                end
            end
            SEND: begin
                if (eob_reg) begin
                    shreg_next = shreg_reg << 1;
                    tick_next  = '0;
                    if (bit_cnt_reg == BIT_W'(FRAME_W - 1)) begin
                        state_next = LATCH;
                    end else begin
                        bit_cnt_next = bit_cnt_reg + 1'b1;
                    end
                end else begin
                    tick_next = tick_reg + 1'b1;
                end
            end
            LATCH: begin
                if (tick_reg == TICK_W'(TRESET - 1)) begin
                    state_next = IDLE;
                    tick_next  = '0;
                    done_next  = 1'b1;
                end else begin
                    tick_next = tick_reg + 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
                tick_next  = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= IDLE;
            tick_reg    <= '0;
            bit_cnt_reg <= '0;
            shreg_reg   <= '0;
            done_reg    <= 1'b0;
            dout_reg    <= 1'b0;
            eob_reg     <= 1'b0;
        end else begin
            state_reg   <= state_next;
            tick_reg    <= tick_next;
            bit_cnt_reg <= bit_cnt_next;
            shreg_reg   <= shreg_next;
            done_reg    <= done_next;
            dout_reg    <= (state_next == SEND) && high_next;
            eob_reg     <= (state_next == SEND) && eob_next;
        end
    end

    assign busy = (state_reg != IDLE);
    assign done = done_reg;
    assign dout = dout_reg;

endmodule

// File: tb/tb_ws2812_tx.sv
// Bench for ws2812_tx with a small chain and short timings; every cycle's
// dout/busy/done is compared against a waveform model derived from the frame.
module tb_ws2812_tx;
    import ws2812_pkg::*;

    localparam int NUM_LEDS = 1;
    localparam int T0H      = 2;
    localparam int T1H      = 4;
    localparam int TBIT     = 6;
    localparam int TRESET   = 10;
    localparam int FW       = NUM_LEDS * BITS_PER_LED;
    localparam int SEND_END = FW * TBIT;            // last offset of the bit stream
    localparam int LAT_END  = SEND_END + TRESET;    // last offset of the latch
    localparam int DONE_K   = LAT_END + 1;          // offset of the done pulse

    logic          clk = 1'b0;
    logic          reset;
    logic [FW-1:0] frame;
    logic          start;
    logic          busy;
    logic          done;
    logic          dout;

    int compared   = 0;
    int mismatched = 0;
    int cycle_no   = 0;

    // Model: m_k is the cycle offset from the accepting edge, 0 when idle.
    int            m_k = 0;
    logic [FW-1:0] m_frame = '0;

    ws2812_tx #(
        .NUM_LEDS (NUM_LEDS),
        .T0H      (T0H),
        .T1H      (T1H),
        .TBIT     (TBIT),
        .TRESET   (TRESET)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .frame (frame),
        .start (start),
        .busy  (busy),
        .done  (done),
        .dout  (dout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL %s cycle %0d offset %0d: got %0h expected %0h", tag, cycle_no, m_k, got, exp);
        end
    endtask

    // {dout, busy, done} expected in the cycle at offset k of a frame f.
    function automatic logic [2:0] model_out(input int k, input logic [FW-1:0] f);
        int  i;
        int  t;
        logic b;
        if (k >= 1 && k <= SEND_END) begin
            i = (k - 1) / TBIT;
            t = (k - 1) % TBIT;
            b = f[FW-1-i];
            return {(t < (b ? T1H : T0H)), 1'b1, 1'b0};
        end else if (k > SEND_END && k <= LAT_END) begin
            return 3'b010;
        end else if (k == DONE_K) begin
            return 3'b001;
        end
        return 3'b000;
    endfunction

    // One cycle: check the current outputs, then drive the inputs for the
    // coming edge and advance the model by what that edge will do.
    task automatic cycle(input logic r, input logic s, input logic [FW-1:0] f);
        logic [2:0] e;
        @(negedge clk);
        cycle_no++;
        e = model_out(m_k, m_frame);
        check("dout", {31'd0, dout}, {31'd0, e[2]});
        check("busy", {31'd0, busy}, {31'd0, e[1]});
        check("done", {31'd0, done}, {31'd0, e[0]});
        if (m_k == DONE_K)
            $display("cycle %0d: frame %06h done", cycle_no, m_frame);
        reset = r;
        start = s;
        frame = f;
        if (r) begin
            if (m_k != 0 && m_k != DONE_K)
                $display("cycle %0d: frame %06h aborted by reset", cycle_no, m_frame);
            m_k = 0;
        end else if ((m_k == 0 || m_k == DONE_K) && s) begin
            m_k     = 1;
            m_frame = f;
            $display("cycle %0d: frame %06h accepted", cycle_no, f);
        end else if (m_k == DONE_K) begin
            m_k = 0;
        end else if (m_k != 0) begin
            m_k++;
        end
    endtask

    initial begin
        logic [FW-1:0] f0;
        logic [FW-1:0] f1;
        reset = 1'b1;
        start = 1'b0;
        frame = '0;
        @(posedge clk);

        // Reset held, then released with start low.
        for (int j = 0; j < 3; j++) cycle(1'b1, 1'b0, '0);
        for (int j = 0; j < 3; j++) cycle(1'b0, 1'b0, '0);

        // Single frame with '1' at both ends.
        cycle(1'b0, 1'b1, 24'h800001);
        for (int j = 1; j <= DONE_K + 3; j++) cycle(1'b0, 1'b0, 24'h800001);

        // Start while busy is ignored.
        f0 = FW'($urandom);
        f1 = ~f0;
        cycle(1'b0, 1'b1, f0);
        for (int j = 1; j <= DONE_K + 3; j++) cycle(1'b0, (j == 50), (j >= 50) ? f1 : f0);

        // Frame changes after capture.
        f0 = FW'($urandom) & 24'h7F7F7F;
        cycle(1'b0, 1'b1, f0);
        for (int j = 1; j <= DONE_K + 3; j++) cycle(1'b0, 1'b0, (j >= 3) ? 24'hFFFFFF : f0);

        // Back-to-back frames with start held high.
        for (int j = 0; j < 3 * DONE_K + 2; j++) cycle(1'b0, 1'b1, FW'($urandom));
        for (int j = 0; j < DONE_K + 3; j++) cycle(1'b0, 1'b0, '0);

        // Reset mid-frame, then a full frame after release.
        cycle(1'b0, 1'b1, FW'($urandom));
        for (int j = 1; j <= 60; j++) cycle((j == 40), 1'b0, FW'($urandom));
        f0 = FW'($urandom);
        cycle(1'b0, 1'b1, f0);
        for (int j = 1; j <= DONE_K + 3; j++) cycle(1'b0, 1'b0, f0);

        // Random frames, gaps, start noise and frame churn.
        for (int n = 0; n < 6; n++) begin
            int gap;
            gap = $urandom_range(0, 4);
            for (int j = 0; j < gap; j++) cycle(1'b0, 1'b0, FW'($urandom));
            cycle(1'b0, 1'b1, (n == 0) ? GREEN : FW'($urandom));
            for (int j = 1; j <= DONE_K; j++)
                cycle(1'b0, ($urandom_range(0, 7) == 0), FW'($urandom));
        end
        for (int j = 0; j < DONE_K + 3; j++) cycle(1'b0, 1'b0, '0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/ws2812_tx.md
# ws2812_tx

Serial line driver for the WS2812 LED chain. Captures one full GRB frame from the pattern stage (24 bits per LED, first LED in the most-significant 24 bits) on a start strobe. Shifts the frame out on a single NZR data pin, then holds the line low for the latch/reset interval. Sits directly downstream of the pattern generator and drives the board pin.

## Interface
- NUM_LEDS, 5, number of LEDs in the chain; frame width = NUM_LEDS*24
- T0H, 40, clocks dout is high for a '0' bit (0.4 us at 100 MHz)
- T1H, 80, clocks dout is high for a '1' bit (0.8 us)
- TBIT, 125, total clocks per bit (1.25 us)
- TRESET, 5000, clocks dout is held low after the last bit (50 us)
- clk  in  1  system clock
- reset  in  1  reset, synchronous, active-high
- frame  in  NUM_LEDS*24  GRB data; bit [NUM_LEDS*24-1] is sent first
- start  in  1  request transmission; sampled only when idle
- busy  out  1  high while a frame or latch interval is in progress
- done  out  1  one-cycle pulse when the latch interval completes
- dout  out  1  registered serial data to the LED chain

## Operation
- States: IDLE, SEND, LATCH.
- IDLE:
  - dout=0, busy=0.
  - When start=1 at a rising edge, frame is copied into an internal shift register, the bit counter and tick counter clear, and the state becomes SEND.
  - start while busy is ignored; no queueing.
- SEND:
  - The tick counter runs 0..TBIT-1 per bit.
  - dout=1 while tick < (current bit ? T1H : T0H), else 0.
  - At tick=TBIT-1, the shift register shifts left by one and the bit counter increments.
  - After bit NUM_LEDS*24-1 completes, go to LATCH with tick cleared.
- LATCH: dout=0 for exactly TRESET cycles, then go to IDLE with done=1 for one cycle.
- Changes on frame after capture have no effect on the transmission in progress.
- Counter widths:
  - tick counter is $clog2(max(TBIT,TRESET)) bits.
  - bit counter is $clog2(NUM_LEDS*24) bits.
  - No wrap-around is permitted inside a state.
- Legal parameters: 0 < T0H < T1H < TBIT and TRESET ≥ 1. Elaboration fails otherwise.

## Timing
- Reset values: dout=0, busy=0, done=0, state IDLE, counters 0.
- Reset asserted mid-frame or mid-latch:
  - Abort at that edge. dout=0 and busy=0 from the next cycle.
  - No done pulse.
- Let E0 be the edge where start is accepted.
  - Bit i's high phase begins in cycle E0+1+i*TBIT.
  - busy=1 from cycle E0+1.
- LATCH occupies cycles E0+1+N*TBIT through E0+N*TBIT+TRESET, where N=NUM_LEDS*24.
- done=1 and busy=0 in cycle E0+1+N*TBIT+TRESET.
  - A start in that same cycle is accepted: back-to-back frames with no extra gap.
- Start-to-done latency = N*TBIT+TRESET+1 cycles. With defaults, 20001 cycles.
- dout is driven directly from a flop: no combinational path from frame/start to dout.

## Structure
- Shared package ws2812_pkg holds:
  - the state enum (IDLE, SEND, LATCH);
  - default timing constants for 100 MHz;
  - the GRB colour constants (OFF, RED, ORANGE, GREEN, CYAN, BLUE, VIOLET) that the pattern stage also uses;
  - the BITS_PER_LED=24 constant.
- One natural sub-module, ws2812_bit_timer:
  - Inputs: tick counter and a bit value.
  - Output: the high/low decision, plus an end_of_bit flag.
  - Keeps pulse-width logic separately testable.
- The shift register, bit counter and FSM live in ws2812_tx.

## Test plan
Bench parameters: NUM_LEDS=1, T0H=2, T1H=4, TBIT=6, TRESET=10 unless stated.

- **Single '1'-heavy frame:** frame=24'h800001, start one cycle.
  - Bit 0: dout high 4 cycles, low 2.
  - Bits 1-22: high 2, low 4.
  - Bit 23: high 4, low 2.
  - Then 10 low cycles; done pulses at E0+155.
- **Reset values:** hold reset 3 cycles → dout=0, busy=0, done=0 throughout and after release with start=0.
- **Start while busy:** pulse start again at E0+50 with a different frame.
  - The waveform is unchanged from the first frame.
  - Exactly one done, at E0+155.
- **Frame change after capture:** change frame to 24'hFFFFFF at E0+3 → transmitted bits match the originally captured value.
- **Back-to-back:** hold start=1 continuously.
  - The second frame's first high phase begins at the cycle after done.
  - done is spaced exactly 155 cycles apart.
- **Reset mid-frame:** assert reset at E0+40.
  - dout=0 and busy=0 from E0+41; no done.
  - A new start after release produces a full, correct frame.
